toe_conn_table: RTL

Parametrised connection-table manager for the TCP offload engine, exposed as a 64-bit-write / 32-bit-read memory-mapped slave. Host software writes open or kill requests carrying a connection tuple. The block scans an internal table of `MAX_CONN` entries for duplicates, then allocates or frees a connection ID. Results are returned through a DONE/ERROR/ID status word. It replaces the single-shot, unchecked connection-init path with real lookup, allocation, teardown and error reporting.

---
 rtl/toe_conn_table_if.sv | 20 ++
 rtl/toe_conn_table.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/toe_conn_table_if.sv
// Memory-mapped slave bus for the connection-table manager:
// 64-bit write path, 32-bit registered read path.
interface toe_conn_table_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic        address;
  logic [63:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );
endinterface

// File: rtl/toe_conn_table.sv
// Connection-table manager: duplicate scan, lowest-free allocation, teardown
// and DONE/ERROR/ID status reporting behind a memory-mapped slave.
module toe_conn_table #(
  parameter int MAX_CONN = 16,
  parameter int ID_W     = 4,
  parameter int KEY_W    = 36
) (
  input  logic             clk,
  input  logic             reset,
  toe_conn_table_if.slave  bus
);

  localparam int ACNT_W  = ID_W + 1;
  // Key field starts at bit 8 unless a wide KILL_ID pushes it up.
  localparam int KEY_LSB = (ID_W > 4) ? ID_W + 4 : 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT,
    KILL
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     scan_idx_q, scan_idx_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [ID_W-1:0]     kill_id_q, kill_id_d;
  logic                match_found_q, match_found_d;
  logic [ID_W-1:0]     match_idx_q, match_idx_d;
  logic                free_found_q, free_found_d;
  logic [ID_W-1:0]     free_idx_q, free_idx_d;
  logic [MAX_CONN-1:0] valid_q, valid_d;
  logic [ACNT_W-1:0]   active_cnt_q, active_cnt_d;
  logic [ID_W-1:0]     new_id_q, new_id_d;
  logic                error_q, error_d;
  logic [2:0]          err_code_q, err_code_d;
  logic                drop_q, drop_d;
  logic [31:0]         readdata_q, readdata_d;

  logic [KEY_W-1:0]    key_mem_q [MAX_CONN];
  logic                mem_we;
  logic [ID_W-1:0]     mem_waddr;

  logic                done;
  logic                wr_cmd;
  logic                wd_new;
  logic                wd_kill;
  logic [ID_W-1:0]     wd_kill_id;
  logic [KEY_W-1:0]    wd_key;
  logic [31:0]         status_w;
  logic                unused_wd;

  assign done       = (state_q == IDLE);
  assign wr_cmd     = bus.chipselect & bus.write & ~bus.address;
  assign wd_new     = bus.writedata[0];
  assign wd_kill    = bus.writedata[1];
  assign wd_kill_id = bus.writedata[4 +: ID_W];
  assign wd_key     = bus.writedata[KEY_LSB +: KEY_W];
  assign unused_wd  = ^bus.writedata;
  assign bus.readdata = readdata_q;

  // Status word as seen by address 0 reads.
  always_comb begin
    status_w        = '0;
    status_w[15:0]  = 16'(new_id_q);
    status_w[16]    = done;
    status_w[17]    = error_q;
    status_w[20:18] = err_code_q;
    status_w[21]    = drop_q;
  end

  // Next-state, table update and status update.
  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    key_d         = key_q;
    kill_id_d     = kill_id_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    valid_d       = valid_q;
    active_cnt_d  = active_cnt_q;
    new_id_d      = new_id_q;
    error_d       = error_q;
    err_code_d    = err_code_q;
    drop_d        = drop_q;
    mem_we        = 1'b0;
    mem_waddr     = '0;

    if (wr_cmd && !done) begin
      drop_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_cmd) begin
          unique case ({wd_kill, wd_new})
            2'b01: begin
              key_d         = wd_key;
              scan_idx_d    = '0;
              match_found_d = 1'b0;
              free_found_d  = 1'b0;
              drop_d        = 1'b0;
              state_d       = SCAN;
            end
            2'b10: begin
              kill_id_d = wd_kill_id;
              drop_d    = 1'b0;
              state_d   = KILL;
            end
            2'b11: begin
              error_d    = 1'b1;
              err_code_d = 3'd4;
              drop_d     = 1'b0;
            end
            default: ;
          endcase
        end
      end

      SCAN: begin
        if (valid_q[scan_idx_q] && (key_mem_q[scan_idx_q] == key_q) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
        if (!valid_q[scan_idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        if (scan_idx_q == ID_W'(MAX_CONN - 1)) begin
          state_d = COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + ID_W'(1);
        end
      end

      COMMIT: begin
        if (match_found_q) begin
          error_d    = 1'b1;
          err_code_d = 3'd1;
          new_id_d   = match_idx_q;
        end else if (free_found_q) begin
          mem_we              = 1'b1;
          mem_waddr           = free_idx_q;
          valid_d[free_idx_q] = 1'b1;
          active_cnt_d        = active_cnt_q + ACNT_W'(1);
          new_id_d            = free_idx_q;
          error_d             = 1'b0;
          err_code_d          = 3'd0;
        end else begin
          error_d    = 1'b1;
          err_code_d = 3'd2;
        end
        state_d = IDLE;
      end

      KILL: begin
        if (valid_q[kill_id_q]) begin
          valid_d[kill_id_q] = 1'b0;
          active_cnt_d       = active_cnt_q - ACNT_W'(1);
          error_d            = 1'b0;
          err_code_d         = 3'd0;
        end else begin
          error_d    = 1'b1;
          err_code_d = 3'd3;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered read data; holds when no read strobe.
  always_comb begin
    readdata_d = readdata_q;
    if (bus.chipselect && bus.read) begin
      readdata_d = bus.address ? 32'(active_cnt_q) : status_w;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      key_q         <= '0;
      kill_id_q     <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      valid_q       <= '0;
      active_cnt_q  <= '0;
      new_id_q      <= '0;
      error_q       <= 1'b0;
      err_code_q    <= '0;
      drop_q        <= 1'b0;
      readdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      key_q         <= key_d;
      kill_id_q     <= kill_id_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      valid_q       <= valid_d;
      active_cnt_q  <= active_cnt_d;
      new_id_q      <= new_id_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
      drop_q        <= drop_d;
      readdata_q    <= readdata_d;
    end
  end

  // Key storage; contents survive reset, validity lives in valid_q.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      key_mem_q[mem_waddr] <= key_q;
    end
  end

endmodule
